seq_mult_core: RTL

//  Parametrised shift-add sequential multiplier: FSM, datapath and result register in one block.

---
 rtl/seq_mult_core.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_mult_core.sv
// Shift-add sequential multiplier with optional early exit, signed/unsigned
// operands, a start/busy/done handshake and a synchronous abort.
module seq_mult_core #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Exit test shared by LOAD (current B/cnt) and SHIFT (post-shift B/cnt).
  function automatic state_t next_test(input logic [WIDTH-1:0] b, input logic [CW-1:0] c);
    if ((EARLY_EXIT && (b == '0)) || (c == CW'(WIDTH)))
      return S_FIX;
    else if (b[0])
      return S_ADD;
    else
      return S_SHIFT;
  endfunction

  always_comb begin
    a_mag = a_in;
    b_mag = b_in;
    if (signed_mode && a_in[WIDTH-1]) a_mag = (~a_in) + {{(WIDTH-1){1'b0}}, 1'b1};
    if (signed_mode && b_in[WIDTH-1]) b_mag = (~b_in) + {{(WIDTH-1){1'b0}}, 1'b1};
    p_fix = neg ? ((~p_q) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
        S_LOAD:  state_nxt = next_test(b_q, cnt);
        S_ADD:   state_nxt = S_SHIFT;
        S_SHIFT: state_nxt = next_test(b_q >> 1, cnt + CW'(1));
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // busy/done are registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              a_q <= {{WIDTH{1'b0}}, a_mag};
              b_q <= b_mag;
              p_q <= '0;
              cnt <= '0;
              neg <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            end
          end
          S_ADD: p_q <= p_q + a_q;
          S_SHIFT: begin
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
            cnt <= cnt + CW'(1);
          end
          S_FIX: begin
            p_q     <= p_fix;
            product <= p_fix;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
